// File: rtl/pwm_mode_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_mode_sequencer: steps a duty-engine state index through per-state dwell
// times (ms), with start/stop/pause control. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_mode_sequencer #(
  parameter int NUM_STATES    = 6,
  parameter int DWELL_W       = 16,
  parameter int DEFAULT_DWELL = 1000,
  parameter int LOOP          = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ms_tick,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [2:0]         current_state,
  output logic               running,
  output logic               paused,
  output logic               seq_wrap,
  output logic               seq_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } fsm_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_STATES - 1);

  fsm_t               fsm_q, fsm_d;
  logic [2:0]         cur_q, cur_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q [NUM_STATES];
  logic [DWELL_W-1:0] dwell_sel;
  logic [DWELL_W:0]   eff_dwell;
  logic [DWELL_W:0]   cnt_inc;
  logic               wrap_d, done_d;
  logic               running_q, paused_q, wrap_q, done_q;

  always_comb begin
    dwell_sel = dwell_q[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (cur_q == 3'(i)) dwell_sel = dwell_q[i];
    end
  end

  // A programmed dwell of 0 behaves as 1 ms; the compare is one bit wider so
  // cnt+1 never wraps.
  assign eff_dwell = (dwell_sel == '0) ? (DWELL_W+1)'(1) : {1'b0, dwell_sel};
  assign cnt_inc   = {1'b0, cnt_q} + (DWELL_W+1)'(1);

  always_comb begin
    fsm_d  = fsm_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    done_d = 1'b0;
    if (stop) begin
      fsm_d = IDLE;
      cur_d = '0;
      cnt_d = '0;
    end else if (start && fsm_q == IDLE) begin
      fsm_d = RUN;
      cur_d = '0;
      cnt_d = '0;
    end else if (pause && fsm_q == RUN) begin
      fsm_d = PAUSED;
    end else if (pause && fsm_q == PAUSED) begin
      fsm_d = RUN;
    end else if (fsm_q == RUN && ms_tick) begin
      if (cnt_inc >= eff_dwell) begin
        cnt_d = '0;
        if (cur_q != LAST_IDX) begin
          cur_d = cur_q + 3'd1;
        end else begin
          cur_d = '0;
          if (LOOP != 0) begin
            wrap_d = 1'b1;
          end else begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_inc[DWELL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      cur_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      running_q <= (fsm_d == RUN);
      paused_q  <= (fsm_d == PAUSED);
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  // Writes land after this cycle's advance decision, which used the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STATES; i++) dwell_q[i] <= DWELL_W'(DEFAULT_DWELL);
    end else begin
      for (int i = 0; i < NUM_STATES; i++) begin
        if (cfg_we && cfg_addr == 3'(i)) dwell_q[i] <= cfg_dwell;
      end
    end
  end

  assign current_state = cur_q;
  assign running       = running_q;
  assign paused        = paused_q;
  assign seq_wrap      = wrap_q;
  assign seq_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_mode_sequencer.sv
// Testbench for pwm_mode_sequencer: one LOOP=0 and one LOOP=1 instance share
// stimulus and are compared against a per-cycle behavioural model.
`default_nettype none

module tb_pwm_mode_sequencer;
  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int DEF = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ms_tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [2:0]    cs0, cs1;
  logic          run0, run1, pau0, pau1, wrap0, wrap1, done0, done1;

  always #5 clk = ~clk;

  pwm_mode_sequencer #(.NUM_STATES(N), .DWELL_W(DW), .DEFAULT_DWELL(DEF), .LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .start(start), .stop(stop), .pause(pause),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dwell(cfg_dwell),
    .current_state(cs0), .running(run0), .paused(pau0), .seq_wrap(wrap0), .seq_done(done0));

  pwm_mode_sequencer #(.NUM_STATES(N), .DWELL_W(DW), .DEFAULT_DWELL(DEF), .LOOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .start(start), .stop(stop), .pause(pause),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dwell(cfg_dwell),
    .current_state(cs1), .running(run1), .paused(pau1), .seq_wrap(wrap1), .seq_done(done1));

  wire [6:0] obs0 = {cs0, run0, pau0, wrap0, done0};
  wire [6:0] obs1 = {cs1, run1, pau1, wrap1, done1};

  int checks = 0;
  int failures = 0;

  // Model: mode 0=idle 1=run 2=paused; index k is the LOOP value.
  int m_mode [2];
  int m_idx  [2];
  int m_cnt  [2];
  bit m_wrap [2];
  bit m_done [2];
  int m_dw   [N];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_idx[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
    end
    for (int i = 0; i < N; i++) m_dw[i] = DEF;
  endfunction

  function automatic void model_step(bit st, bit sp, bit pa, bit tk, bit we, int addr, int val);
    int limit;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      m_done[k] = 0;
      if (sp) begin
        m_mode[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
      end else if (st && m_mode[k] == 0) begin
        m_mode[k] = 1; m_idx[k] = 0; m_cnt[k] = 0;
      end else if (pa && m_mode[k] != 0) begin
        m_mode[k] = 3 - m_mode[k];
      end else if (m_mode[k] == 1 && tk) begin
        limit = (m_dw[m_idx[k]] == 0) ? 1 : m_dw[m_idx[k]];
        if (m_cnt[k] + 1 >= limit) begin
          m_cnt[k] = 0;
          if (m_idx[k] == N - 1) begin
            m_idx[k] = 0;
            if (k == 1) m_wrap[k] = 1;
            else begin m_mode[k] = 0; m_done[k] = 1; end
          end else begin
            m_idx[k] = m_idx[k] + 1;
          end
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    if (we && addr < N) m_dw[addr] = val;
  endfunction

  function automatic logic [6:0] exp_vec(int k);
    return {3'(m_idx[k]), m_mode[k] == 1, m_mode[k] == 2, m_wrap[k], m_done[k]};
  endfunction

  // Called at posedge+1; inputs are held across the next edge, then released.
  task automatic cyc(input bit st, input bit sp, input bit pa, input bit tk,
                     input bit we = 0, input int addr = 0, input int val = 0);
    start = st; stop = sp; pause = pa; ms_tick = tk; cfg_we = we;
    cfg_addr = 3'(addr); cfg_dwell = DW'(val);
    @(posedge clk);
    model_step(st, sp, pa, tk, we, addr, val);
    #1;
    start = 0; stop = 0; pause = 0; ms_tick = 0; cfg_we = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    checks++;
    if (obs0 !== 7'd0 || obs1 !== 7'd0) begin
      failures++;
      $display("FAIL reset_outputs loop0=%b loop1=%b required=0000000", obs0, obs1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 1);
    checks++;
    if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
      failures++;
      $display("FAIL idle_tick loop0=%b loop1=%b required=%b/%b", obs0, obs1, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_sequence_end();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    for (int t = 1; t <= 6; t++) begin
      cyc(0, 0, 0, 1);
      checks++;
      if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
        failures++;
        $display("FAIL seq_tick%0d loop0=%b loop1=%b required=%b/%b", t, obs0, obs1, exp_vec(0), exp_vec(1));
      end
    end
    checks++;
    if (done0 !== 1'b1 || run0 !== 1'b0 || cs0 !== 3'd0) begin
      failures++;
      $display("FAIL seq_done_end got done=%b run=%b cs=%0d required done=1 run=0 cs=0", done0, run0, cs0);
    end
    checks++;
    if (wrap1 !== 1'b1 || run1 !== 1'b1 || cs1 !== 3'd0) begin
      failures++;
      $display("FAIL seq_wrap_end got wrap=%b run=%b cs=%0d required wrap=1 run=1 cs=0", wrap1, run1, cs1);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (done0 !== 1'b0 || wrap1 !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width got done=%b wrap=%b required 0/0", done0, wrap1);
    end
  endtask

  task automatic test_pause();
    logic [2:0] held;
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    held = 3'(m_idx[0]);
    for (int t = 0; t < 5; t++) begin
      cyc(0, 0, 0, 1);
      checks++;
      if (obs0 !== exp_vec(0) || cs0 !== held || pau0 !== 1'b1) begin
        failures++;
        $display("FAIL pause_hold got %b required %b (state %0d)", obs0, exp_vec(0), held);
      end
    end
    cyc(0, 0, 1, 0);
    repeat (2) begin
      cyc(0, 0, 0, 1);
      checks++;
      if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
        failures++;
        $display("FAIL pause_resume loop0=%b loop1=%b required=%b/%b", obs0, obs1, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  task automatic test_cfg();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 5, 9);
    cyc(1, 0, 0, 0);
    for (int t = 1; t <= 5; t++) begin
      cyc(0, 0, 0, 1);
      checks++;
      if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
        failures++;
        $display("FAIL cfg_tick%0d loop0=%b loop1=%b required=%b/%b", t, obs0, obs1, exp_vec(0), exp_vec(1));
      end
      if (t == 3) begin
        checks++;
        if (cs0 !== 3'd2) begin
          failures++;
          $display("FAIL cfg_zero_dwell got cs=%0d required cs=2", cs0);
        end
      end
    end
    cyc(0, 0, 0, 0, 1, 1, DEF);
  endtask

  task automatic test_collide();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 1);
    checks++;
    if (cs0 !== 3'd0 || run0 !== 1'b0 || done0 !== 1'b0 || obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
      failures++;
      $display("FAIL stop_start_tick loop0=%b loop1=%b required=%b/%b", obs0, obs1, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_cfg_coincide();
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 0, 9);
    checks++;
    if (cs0 !== 3'd1 || obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
      failures++;
      $display("FAIL cfg_old_value loop0=%b loop1=%b required=%b/%b", obs0, obs1, exp_vec(0), exp_vec(1));
    end
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1);
    checks++;
    if (cs0 !== 3'd2 || obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
      failures++;
      $display("FAIL cfg_shrink_active loop0=%b loop1=%b required=%b/%b", obs0, obs1, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      cyc($urandom_range(99) < 6, $urandom_range(99) < 2, $urandom_range(99) < 5,
          $urandom_range(99) < 50, $urandom_range(99) < 10,
          int'($urandom_range(7)), int'($urandom_range(4)));
      checks++;
      if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
        failures++;
        $display("FAIL random_c%0d loop0=%b loop1=%b required=%b/%b", c, obs0, obs1, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 0, 1, 0, 4);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs0 !== 7'd0 || obs1 !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid loop0=%b loop1=%b required=0000000", obs0, obs1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 0, 0, 0);
    for (int t = 1; t <= 6; t++) begin
      cyc(0, 0, 0, 1);
      checks++;
      if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
        failures++;
        $display("FAIL post_reset_tick%0d loop0=%b loop1=%b required=%b/%b", t, obs0, obs1, exp_vec(0), exp_vec(1));
      end
      if (t == 2) begin
        checks++;
        if (cs0 !== 3'd1) begin
          failures++;
          $display("FAIL default_dwell got cs=%0d required cs=1", cs0);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_sequence_end();
    test_pause();
    test_cfg();
    test_collide();
    test_cfg_coincide();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
